// File: rtl/fir_pkg.sv
// Shared FIR-path definitions: sample width, sample type and tap count.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

    localparam int SAMPLE_W = 16;
    localparam int NUM_TAPS = 10;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a push at edge n is visible on dout from edge n+1 when empty.
// Backpressure: push is accepted when not full, or when full with a same-cycle pop.
//
// Ports: clock/reset (sync, active high); push/din write side; pop read side
// (ignored while empty); dout head entry (0 while empty); full, empty, count.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fir_decim_buffer.sv
// Decimates FIR output (keeps every (decim+1)-th valid sample) into a FWFT FIFO.
// Latency: a sample kept at edge n is on dout with dout_valid from edge n+1 when empty.
// Backpressure: valid/ready output; kept samples arriving while full without a pop are dropped and counted.
//
// Ports: clock, reset (sync, active high); y/y_valid sample input; decim = factor-1;
// clr_ovf clears overflow/drop_count; dout/dout_valid/dout_ready output stream;
// count FIFO occupancy; overflow sticky drop flag; drop_count saturating drop total.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int WIDTH   = SAMPLE_W,
    parameter int DEPTH   = 8,
    parameter int DECIM_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         y,
    input  logic                     y_valid,
    input  logic [DECIM_W-1:0]       decim,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    logic [DECIM_W-1:0] phase;
    logic [DECIM_W-1:0] decim_q;
    logic               keep;
    logic               pop;
    logic               full;
    logic               empty;
    logic               drop;

    assign keep       = y_valid && !reset && (phase == '0);
    assign dout_valid = !empty;
    assign pop        = dout_valid && dout_ready;
    assign drop       = keep && full && !pop;

    // Phase counter; decim_q only reloads at a frame boundary so a mid-frame
    // change of decim never shortens or stretches the frame in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase   <= '0;
            decim_q <= decim;
        end else if (y_valid) begin
            if (phase == decim_q) begin
                phase   <= '0;
                decim_q <= decim;
            end else begin
                phase <= phase + DECIM_W'(1);
            end
        end
    end

    // A drop in the same cycle as clr_ovf wins: it restarts the count at 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)
                drop_count <= 8'd1;
            else if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (keep),
        .din   (y),
        .pop   (dout_ready),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Randomized and directed bench for fir_decim_buffer against a queue-based model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fir_decim_buffer;
    import fir_pkg::*;

    localparam int WIDTH   = SAMPLE_W;
    localparam int DEPTH   = 8;
    localparam int DECIM_W = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clock      = 1'b0;
    logic               reset      = 1'b1;
    logic [WIDTH-1:0]   y          = '0;
    logic               y_valid    = 1'b0;
    logic [DECIM_W-1:0] decim      = '0;
    logic               clr_ovf    = 1'b0;
    logic [WIDTH-1:0]   dout;
    logic               dout_valid;
    logic               dout_ready = 1'b0;
    logic [CW-1:0]      count;
    logic               overflow;
    logic [7:0]         drop_count;

    fir_decim_buffer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .DECIM_W (DECIM_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .y          (y),
        .y_valid    (y_valid),
        .decim      (decim),
        .clr_ovf    (clr_ovf),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: samples held, position within the current frame,
    // current frame length, sticky flag and drop total.
    int q[$];
    int frame_pos = 0;
    int frame_len = 1;
    int ovf_m     = 0;
    int drops_m   = 0;
    int seen[$];
    int maxcnt;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: log pre-edge handshake, advance model, then compare all outputs.
    task automatic step();
        bit pop_m;
        bit keep_m;
        bit drop_m;
        if (!reset && dout_valid && dout_ready) seen.push_back(int'(dout));
        @(posedge clock);
        if (reset) begin
            q.delete();
            frame_pos = 0;
            frame_len = int'(decim) + 1;
            ovf_m     = 0;
            drops_m   = 0;
        end else begin
            pop_m  = (q.size() != 0) && dout_ready;
            keep_m = y_valid && (frame_pos == 0);
            if (y_valid) begin
                frame_pos++;
                if (frame_pos == frame_len) begin
                    frame_pos = 0;
                    frame_len = int'(decim) + 1;
                end
            end
            drop_m = keep_m && (q.size() == DEPTH) && !pop_m;
            if (pop_m) void'(q.pop_front());
            if (keep_m && !drop_m) q.push_back(int'(y));
            if (drop_m) begin
                ovf_m   = 1;
                drops_m = clr_ovf ? 1 : ((drops_m < 255) ? drops_m + 1 : 255);
            end else if (clr_ovf) begin
                ovf_m   = 0;
                drops_m = 0;
            end
        end
        #1;
        check_eq("count", int'(count), q.size());
        check_eq("dout_valid", int'(dout_valid), (q.size() != 0) ? 1 : 0);
        check_eq("dout", int'(dout), (q.size() != 0) ? q[0] : 0);
        check_eq("overflow", int'(overflow), ovf_m);
        check_eq("drop_count", int'(drop_count), drops_m);
        if (int'(count) > maxcnt) maxcnt = int'(count);
    endtask

    // Reset with y_valid high to show it is ignored during reset.
    task automatic do_reset();
        reset   = 1'b1;
        y_valid = 1'b1;
        clr_ovf = 1'b0;
        step();
        reset   = 1'b0;
        y_valid = 1'b0;
    endtask

    task automatic push(input int v);
        y       = WIDTH'(v);
        y_valid = 1'b1;
        step();
        y_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        decim = '0;
        step();
        do_reset();
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_valid", int'(dout_valid), 0);
        check_eq("rst_dout", int'(dout), 0);
        check_eq("rst_ovf", int'(overflow), 0);
        check_eq("rst_drops", int'(drop_count), 0);

        // 1: keep all, no stall
        dout_ready = 1'b1;
        seen.delete();
        maxcnt = 0;
        for (int i = 1; i <= 10; i++) begin
            y = WIDTH'(i); y_valid = 1'b1; step();
        end
        y_valid = 1'b0;
        step(); step();
        check_eq("t1_maxcnt", maxcnt, 1);
        check_eq("t1_n", seen.size(), 10);
        for (int i = 0; i < 10 && i < seen.size(); i++) check_eq("t1_data", seen[i], i + 1);

        // 2: decimate by 4, then by 2 from the next frame
        decim = 4'd3;
        do_reset();
        seen.delete();
        for (int v = 0; v <= 18; v++) begin
            if (v == 13) decim = 4'd1;
            y = WIDTH'(v); y_valid = 1'b1; step();
        end
        y_valid = 1'b0;
        step(); step(); step();
        begin
            int exp2[6] = '{0, 4, 8, 12, 16, 18};
            check_eq("t2_n", seen.size(), 6);
            for (int i = 0; i < 6 && i < seen.size(); i++) check_eq("t2_data", seen[i], exp2[i]);
        end

        // 3: backpressure and overflow
        decim = '0;
        dout_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) push(100 + i);
        step();
        check_eq("t3_count", int'(count), 8);
        check_eq("t3_ovf", int'(overflow), 1);
        check_eq("t3_drops", int'(drop_count), 2);
        dout_ready = 1'b1;
        seen.delete();
        for (int i = 0; i < 9; i++) step();
        check_eq("t3_n", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++) check_eq("t3_data", seen[i], 100 + i);
        check_eq("t3_empty", int'(dout_valid), 0);

        // 4: full with simultaneous push/pop
        dout_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) push(300 + i);
        dout_ready = 1'b1;
        seen.delete();
        for (int i = 0; i < 12; i++) begin
            y = WIDTH'(310 + i); y_valid = 1'b1; step();
            check_eq("t4_count", int'(count), 8);
            check_eq("t4_drops", int'(drop_count), 0);
        end
        y_valid = 1'b0;
        dout_ready = 1'b0;
        step();
        check_eq("t4_n", seen.size(), 12);
        for (int i = 0; i < 12 && i < seen.size(); i++)
            check_eq("t4_data", seen[i], (i < 8) ? 300 + i : 310 + i - 8);

        // 5: reset mid-stream with count 5 and phase 2
        decim = 4'd3;
        do_reset();
        for (int i = 0; i < 18; i++) push(i);
        check_eq("t5_pre_count", int'(count), 5);
        decim = '0;
        do_reset();
        check_eq("t5_count", int'(count), 0);
        check_eq("t5_valid", int'(dout_valid), 0);
        check_eq("t5_dout", int'(dout), 0);
        push(555);
        check_eq("t5_kept_count", int'(count), 1);
        check_eq("t5_kept_dout", int'(dout), 555);

        // 6: clr_ovf with and without a coincident drop
        do_reset();
        for (int i = 0; i < 10; i++) push(700 + i);
        check_eq("t6_pre_drops", int'(drop_count), 2);
        clr_ovf = 1'b1;
        push(999);
        clr_ovf = 1'b0;
        check_eq("t6_drop_ovf", int'(overflow), 1);
        check_eq("t6_drop_cnt", int'(drop_count), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check_eq("t6_clr_ovf", int'(overflow), 0);
        check_eq("t6_clr_cnt", int'(drop_count), 0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            y          = WIDTH'($urandom_range(0, 65535));
            y_valid    = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 2) == 0);
            clr_ovf    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) decim = DECIM_W'($urandom_range(0, 15));
            else if ($urandom_range(0, 299) == 0) decim = '0;
            step();
        end
        reset = 1'b0; y_valid = 1'b0; clr_ovf = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
